// File: rtl/pipe_cla_add.sv
// Pipelined carry-lookahead adder: each stage resolves B sum bits and hands its carry to the next stage.
// Optional macro PIPE_CLA_ADD_OVF_EN adds a registered signed-overflow output ovf aligned with sum.
module pipe_cla_add #(
    parameter int N = 32,
    parameter int B = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout
`ifdef PIPE_CLA_ADD_OVF_EN
    ,output logic        ovf
`endif
);

    localparam int S = N / B;

    if (B < 2 || N < B || (N % B) != 0) begin : g_bad_params
        $error("pipe_cla_add: N must be a multiple of B, with B >= 2 and N >= B");
    end

    // Every carry is a flat sum of generate/propagate products, so no carry waits on another.
    function automatic logic [B:0] cla_block(input logic [B-1:0] x, input logic [B-1:0] y,
                                             input logic c0);
        logic [B-1:0] g;
        logic [B-1:0] p;
        logic [B:0]   c;
        logic         term;
        logic         gp;
        g    = x & y;
        p    = x ^ y;
        c    = {(B+1){1'b0}};
        c[0] = c0;
        for (int i = 0; i < B; i++) begin
            term = c0;
            for (int j = 0; j <= i; j++) begin
                term = term & p[j];
            end
            for (int j = 0; j <= i; j++) begin
                gp = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    gp = gp & p[m];
                end
                term = term | gp;
            end
            c[i+1] = term;
        end
        return {c[B], p ^ c[B-1:0]};
    endfunction

    logic [N-1:0] a_r     [S];
    logic [N-1:0] b_r     [S];
    logic [N-1:0] sum_r   [S];
    logic         carry_r [S];
    logic [S-1:0] valid_r;

    logic [N-1:0] a_in    [S];
    logic [N-1:0] b_in    [S];
    logic [N-1:0] s_in    [S];
    logic         c_in    [S];
    logic [S-1:0] v_in;
    logic [B:0]   blk     [S];
    logic [N-1:0] sum_nxt [S];
    logic         adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < S; k++) begin : g_stage
        localparam logic [N-1:0] MASK = N'({B{1'b1}}) << (k * B);
        if (k == 0) begin : g_first
            assign a_in[k] = a;
            assign b_in[k] = b;
            assign s_in[k] = {N{1'b0}};
            assign c_in[k] = cin;
            assign v_in[k] = in_valid;
        end else begin : g_next
            assign a_in[k] = a_r[k-1];
            assign b_in[k] = b_r[k-1];
            assign s_in[k] = sum_r[k-1];
            assign c_in[k] = carry_r[k-1];
            assign v_in[k] = valid_r[k-1];
        end
        assign blk[k]     = cla_block(a_in[k][k*B +: B], b_in[k][k*B +: B], c_in[k]);
        // Splice this stage's freshly resolved bits into the sum already carried down the pipe.
        assign sum_nxt[k] = (s_in[k] & ~MASK) | (N'(blk[k][B-1:0]) << (k * B));
    end

    // Stage registers: shift together on adv, freeze together on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {S{1'b0}};
            for (int k = 0; k < S; k++) begin
                a_r[k]     <= {N{1'b0}};
                b_r[k]     <= {N{1'b0}};
                sum_r[k]   <= {N{1'b0}};
                carry_r[k] <= 1'b0;
            end
        end else if (adv) begin
            valid_r <= v_in;
            for (int k = 0; k < S; k++) begin
                a_r[k]     <= a_in[k];
                b_r[k]     <= b_in[k];
                sum_r[k]   <= sum_nxt[k];
                carry_r[k] <= blk[k][B];
            end
        end
    end

    assign out_valid = valid_r[S-1];
    assign sum       = sum_r[S-1];
    assign cout      = carry_r[S-1];

`ifdef PIPE_CLA_ADD_OVF_EN
    logic ovf_r;
    logic ovf_nxt;

    // The last stage still sees the untouched operand sign bits, so overflow is formed there.
    assign ovf_nxt = (a_in[S-1][N-1] == b_in[S-1][N-1]) &&
                     (sum_nxt[S-1][N-1] != a_in[S-1][N-1]);

    // Overflow flag travels with the final stage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (adv) begin
            ovf_r <= ovf_nxt;
        end
    end

    assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_pipe_cla_add.sv
// Bench for pipe_cla_add: directed latency/stall/reset cases at N=32,B=8 plus
// randomized traffic at 32/8, 16/4 and 8/8 against an arithmetic reference queue.
module tb_pipe_cla_add;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
`ifdef PIPE_CLA_ADD_OVF_EN
    logic        ovf;
`endif

    pipe_cla_add #(.N(32), .B(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PIPE_CLA_ADD_OVF_EN
        ,.ovf      (ovf)
`endif
    );

    // Reference: {ovf, cout, sum} straight from integer addition.
    function automatic logic [33:0] ref32(input logic [31:0] x, input logic [31:0] y, input logic c);
        logic [32:0] t;
        logic        o;
        t = {1'b0, x} + {1'b0, y} + {32'd0, c};
        o = (x[31] == y[31]) && (t[31] != x[31]);
        return {o, t};
    endfunction

    task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y, input logic c);
        in_valid = v;
        a        = x;
        b        = y;
        cin      = c;
    endtask

    task automatic check_out(input string tag, input logic [33:0] e);
        check_val({tag, "_sum"}, 64'(sum), 64'(e[31:0]));
        check_val({tag, "_cout"}, 64'(cout), 64'(e[32]));
`ifdef PIPE_CLA_ADD_OVF_EN
        check_val({tag, "_ovf"}, 64'(ovf), 64'(e[33]));
`endif
    endtask

    // Randomized traffic on three configurations, each with its own queue model.
    for (genvar g = 0; g < 3; g++) begin : g_rnd
        localparam int GN   = (g == 0) ? 32 : ((g == 1) ? 16 : 8);
        localparam int GB   = (g == 1) ? 4 : 8;
        localparam int NVEC = 10000;

        logic          r_rst_n, r_in_valid, r_in_ready, r_cin;
        logic          r_out_valid, r_out_ready, r_cout;
        logic          fin;
        logic [GN-1:0] r_a, r_b, r_sum;
`ifdef PIPE_CLA_ADD_OVF_EN
        logic          r_ovf;
`endif

        pipe_cla_add #(.N(GN), .B(GB)) u_dut (
            .clk       (clk),
            .rst_n     (r_rst_n),
            .in_valid  (r_in_valid),
            .in_ready  (r_in_ready),
            .a         (r_a),
            .b         (r_b),
            .cin       (r_cin),
            .out_valid (r_out_valid),
            .out_ready (r_out_ready),
            .sum       (r_sum),
            .cout      (r_cout)
`ifdef PIPE_CLA_ADD_OVF_EN
            ,.ovf      (r_ovf)
`endif
        );

        initial begin
            logic [GN+1:0] q[$];
            logic [GN+1:0] e;
            logic [GN:0]   t;
            logic [GN:0]   held;
            logic          stalled;
            int            sent;
            int            got;
            int            cyc;
            fin         = 1'b0;
            sent        = 0;
            got         = 0;
            cyc         = 0;
            stalled     = 1'b0;
            held        = {(GN+1){1'b0}};
            r_rst_n     = 1'b0;
            r_in_valid  = 1'b0;
            r_out_ready = 1'b0;
            r_a         = {GN{1'b0}};
            r_b         = {GN{1'b0}};
            r_cin       = 1'b0;
            @(negedge clk);
            r_rst_n = 1'b1;
            while (got < NVEC && cyc < 60000) begin
                @(negedge clk);
                cyc++;
                if (stalled) begin
                    check_val("rnd_hold", 64'({r_out_valid, r_cout, r_sum}), 64'({1'b1, held}));
                end
                r_out_ready = ($urandom_range(3, 0) != 0);
                r_in_valid  = (sent < NVEC) && ($urandom_range(3, 0) != 0);
                r_a         = ($urandom_range(7, 0) == 0) ? {GN{1'b1}} : GN'($urandom);
                r_b         = ($urandom_range(7, 0) == 0) ? ~r_a : GN'($urandom);
                r_cin       = 1'($urandom_range(1, 0));
                #1;
                if (r_out_valid && r_out_ready) begin
                    check_val("rnd_avail", 64'(q.size() != 0), 64'd1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        check_val("rnd_sum", 64'(r_sum), 64'(e[GN-1:0]));
                        check_val("rnd_cout", 64'(r_cout), 64'(e[GN]));
`ifdef PIPE_CLA_ADD_OVF_EN
                        check_val("rnd_ovf", 64'(r_ovf), 64'(e[GN+1]));
`endif
                        got++;
                    end
                end
                if (r_in_valid && r_in_ready) begin
                    t = {1'b0, r_a} + {1'b0, r_b} + {{GN{1'b0}}, r_cin};
                    q.push_back({(r_a[GN-1] == r_b[GN-1]) && (t[GN-1] != r_a[GN-1]), t});
                    sent++;
                end
                stalled = r_out_valid && !r_out_ready;
                held    = {r_cout, r_sum};
            end
            check_val("rnd_count", 64'(got), 64'(NVEC));
            fin = 1'b1;
        end
    end

    initial begin
        logic [31:0] va[4];
        logic [31:0] vb[4];
        logic [33:0] ev[4];
        logic [33:0] e;

        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        #2;
        check_val("rst_valid", 64'(out_valid), 64'd0);
        check_val("rst_sum", 64'(sum), 64'd0);
        check_val("rst_cout", 64'(cout), 64'd0);
        check_val("rst_ready", 64'(in_ready), 64'd1);

        // Full carry ripple through every stage; accepted on the first edge after release.
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        e = ref32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check_val("lat_valid", 64'(out_valid), 64'(i == 4));
            if (i == 1) drive(1'b0, 32'd0, 32'd0, 1'b0);
        end
        check_out("full_carry", e);

        // Back-to-back vectors with sign-boundary cases.
        va[0] = 32'h0000_0001; vb[0] = 32'h0000_0001;
        va[1] = 32'h7FFF_FFFF; vb[1] = 32'h0000_0001;
        va[2] = 32'h8000_0000; vb[2] = 32'h8000_0000;
        @(negedge clk);
        drive(1'b1, va[0], vb[0], 1'b0);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check_val("b2b_valid", 64'(out_valid), 64'(i >= 4));
            if (i >= 4) check_out("b2b", ref32(va[i-4], vb[i-4], 1'b0));
            if (i < 3) drive(1'b1, va[i], vb[i], 1'b0);
            else       drive(1'b0, 32'd0, 32'd0, 1'b0);
        end

        // Fill the pipe, stall five cycles, then drain in order.
        for (int i = 0; i < 4; i++) begin
            va[i] = $urandom;
            vb[i] = $urandom;
            ev[i] = ref32(va[i], vb[i], 1'(i % 2));
            @(negedge clk);
            drive(1'b1, va[i], vb[i], 1'(i % 2));
        end
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        out_ready = 1'b0;
        #1;
        check_val("stall_in_ready", 64'(in_ready), 64'd0);
        for (int s = 0; s < 5; s++) begin
            check_val("stall_valid", 64'(out_valid), 64'd1);
            check_out("stall", ev[0]);
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check_val("drain_valid", 64'(out_valid), 64'd1);
            check_out("drain", ev[j]);
            @(negedge clk);
        end
        check_val("drain_empty", 64'(out_valid), 64'd0);

        // Asynchronous reset with three results in flight.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, $urandom, 1'b1);
            @(negedge clk);
        end
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        check_val("pre_reset_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_valid", 64'(out_valid), 64'd0);
        check_val("async_rst_sum", 64'(sum), 64'd0);
        check_val("async_rst_cout", 64'(cout), 64'd0);
        check_val("async_rst_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_val("post_reset_valid", 64'(out_valid), 64'd0);
        end

        wait (g_rnd[0].fin && g_rnd[1].fin && g_rnd[2].fin);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_cla_add.md
PIPE_CLA_ADD -- requirements
Module: pipe_cla_add

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning operand and sum width in bits.
REQ-002 The block SHALL have parameter B, default 8, meaning lookahead block width, which is also the bits resolved per pipeline stage.
REQ-003 The block SHALL have derived localparam S = N/B, meaning the pipeline stage count and the latency in cycles.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the operand triple is presented.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts the triple this cycle.
REQ-008 The block SHALL have port a, input, N bits: addend.
REQ-009 The block SHALL have port b, input, N bits: addend.
REQ-010 The block SHALL have port cin, input, 1 bit: carry-in.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the result is presented.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 The block SHALL have port sum, output, N bits: (a+b+cin) mod 2^N.
REQ-014 The block SHALL have port cout, output, 1 bit: bit N of a+b+cin.

Function
REQ-015 Legal parameters SHALL be B>=2 and N a multiple of B with N>=B; illegal values SHALL raise an elaboration-time error.
REQ-016 Stage k (0..S-1) SHALL compute result bits [k*B+B-1:k*B] with a B-bit carry-lookahead block (generate/propagate, no ripple chain) using the carry registered by stage k-1; stage 0 SHALL use cin.
REQ-017 Operand bits not yet consumed SHALL travel in skew registers alongside each stage; completed sum bits SHALL be de-skewed so that all N sum bits and cout leave together.
REQ-018 Each stage SHALL carry one valid bit; the advance signal SHALL be adv = !out_valid || out_ready.
REQ-019 in_ready SHALL equal adv; a transfer SHALL occur when in_valid && in_ready.
REQ-020 When adv=1, every stage SHALL shift forward and stage 0 SHALL load the input with valid = in_valid; when adv=0, all stage registers and valid bits SHALL hold.
REQ-021 Latency SHALL be exactly S cycles from input transfer to out_valid=1 with no stall; throughput SHALL be one result per cycle while out_ready=1.
REQ-022 sum and cout SHALL remain stable while out_valid=1 && out_ready=0.
REQ-023 Bubbles (in_valid=0) SHALL propagate as invalid slots; results SHALL emerge in input order with none dropped or duplicated.
REQ-024 Data registers MAY update under invalid slots, but out_valid SHALL reflect only valid bits.
REQ-025 When S=1 the block SHALL behave as a single registered CLA with latency 1.

Reset
REQ-026 On rst_n=0, all valid bits SHALL clear immediately, with out_valid=0, sum=0, cout=0, and in_ready=1 while reset is deasserted-and-empty.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight results; no partial result SHALL appear after release.
REQ-028 The first transfer after reset release SHALL be accepted on the first rising clk edge with rst_n=1.

Configuration
REQ-029 With macro PIPE_CLA_ADD_OVF_EN defined, an output ovf (1 bit) SHALL be added, equal to two's-complement signed overflow: (a[N-1]==b[N-1]) && (sum[N-1]!=a[N-1]), aligned with sum, reset 0, held under stall.
REQ-030 Without PIPE_CLA_ADD_OVF_EN, port ovf and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 N=32,B=8, out_ready=1: a=0xFFFFFFFF, b=0x00000000, cin=1 -> out_valid after exactly 4 cycles, sum=0x00000000, cout=1 (full carry across all stages).
REQ-032 Back-to-back inputs 0x00000001+0x00000001, 0x7FFFFFFF+0x00000001, 0x80000000+0x80000000 (cin=0) -> sums 0x00000002, 0x80000000, 0x00000000 on consecutive cycles; couts 0,0,1; with PIPE_CLA_ADD_OVF_EN, ovf 0,1,1.
REQ-033 Stall: hold out_ready=0 for 5 cycles with a full pipe -> in_ready=0, sum/cout frozen; on release, 4 queued results emerge in order, none lost.
REQ-034 Reset mid-flight: assert rst_n=0 asynchronously with 3 valid slots -> out_valid drops before the next clk edge; after release, no stale result appears.
REQ-035 Random 10k vectors at N=32,B=8, N=16,B=4 and N=8,B=8 with random in_valid/out_ready -> every result matches a+b+cin reference in order.
